// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential floating-point add/subtract unit.
// Holds the FSM state encoding, default field widths, flag bit positions and the qNaN pattern.
package fp_pkg;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MAN_W  = 23;

  localparam int FLAG_OVF   = 2;
  localparam int FLAG_UNF   = 1;
  localparam int FLAG_INX   = 0;

  localparam int QNAN_MAX_W = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_ROUND,
    ST_DONE
  } fp_state_t;

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [QNAN_MAX_W-1:0] qnan_pattern(input int exp_w, input int man_w);
    logic [QNAN_MAX_W-1:0] pat;
    pat = '0;
    for (int i = 0; i < QNAN_MAX_W; i++) begin
      if ((i >= man_w - 1) && (i < man_w + exp_w)) begin
        pat[i] = 1'b1;
      end
    end
    return pat;
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Right shifter for significand alignment; every bit shifted out is ORed into sticky.
// A shift of WIDTH or more clears the output and leaves only the sticky bit.
module fp_align_shift #(
  parameter int WIDTH   = 26,
  parameter int SHIFT_W = 8
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHIFT_W-1:0] shamt,
  output logic [WIDTH-1:0]   dout,
  output logic               sticky
);

  logic [31:0]      shamt_ext;
  logic [WIDTH-1:0] lost_mask;

  assign shamt_ext = 32'(shamt);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lost_mask
      assign lost_mask[gi] = (shamt_ext > 32'(gi));
    end
  endgenerate

  assign dout   = din >> shamt;
  assign sticky = |(din & lost_mask);

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-style add/subtract: align, add, normalise one bit per cycle, round to nearest even.
// Denormal inputs are flushed to zero; Inf/NaN inputs bypass the datapath.
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W,
  parameter int MAN_W = DEF_MAN_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [2:0]             flags
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int ALN_W = MAN_W + 3;
  localparam int SIG_W = MAN_W + 5;
  localparam int E_W   = EXP_W + 2;

  localparam logic signed [E_W-1:0] EXP_ONES  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [E_W-1:0] EXP_ZERO  = '0;
  localparam logic signed [E_W-1:0] EXP_ONE   = {{(E_W-1){1'b0}}, 1'b1};
  localparam logic [QNAN_MAX_W-1:0] QNAN_FULL = qnan_pattern(EXP_W, MAN_W);
  localparam logic [W-1:0]          QNAN      = QNAN_FULL[W-1:0];
  localparam logic [W-2:0]          INF_MAG   = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};

  fp_state_t                state_reg;
  logic [W-1:0]             a_reg;
  logic [W-1:0]             b_reg;
  logic                     sub_reg;
  logic [ALN_W-1:0]         big_sig_reg;
  logic [ALN_W-1:0]         small_sig_reg;
  logic                     small_sticky_reg;
  logic [SIG_W-1:0]         sig_reg;
  logic signed [E_W-1:0]    exp_reg;
  logic                     sign_reg;
  logic                     eff_sub_reg;
  logic                     special_reg;
  logic [W-1:0]             special_res_reg;
  logic [W-1:0]             result_reg;
  logic [2:0]               flags_reg;
  logic                     out_valid_reg;
  logic                     in_ready_reg;

  // Operand decode and magnitude compare (ALIGN)
  logic                     sa, sb;
  logic [EXP_W-1:0]         ea, eb;
  logic [MAN_W-1:0]         fa, fb;
  logic                     a_zero, b_zero, a_max, b_max, a_nan, b_nan;
  logic [W-2:0]             mag_a, mag_b;
  logic                     a_big;
  logic [ALN_W-1:0]         sig_a, sig_b, sig_small;
  logic [EXP_W-1:0]         e_big, e_small, e_diff;
  logic [W-1:0]             spec_res;
  logic [ALN_W-1:0]         aligned_sig;
  logic                     aligned_sticky;

  assign sa     = a_reg[W-1];
  assign sb     = b_reg[W-1] ^ sub_reg;
  assign ea     = a_reg[W-2:MAN_W];
  assign eb     = b_reg[W-2:MAN_W];
  assign fa     = a_reg[MAN_W-1:0];
  assign fb     = b_reg[MAN_W-1:0];
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_max  = &ea;
  assign b_max  = &eb;
  assign a_nan  = a_max && (|fa);
  assign b_nan  = b_max && (|fb);

  // A flushed operand compares as magnitude zero so the other one is always "big".
  assign mag_a     = a_zero ? '0 : a_reg[W-2:0];
  assign mag_b     = b_zero ? '0 : b_reg[W-2:0];
  assign a_big     = (mag_a >= mag_b);
  assign sig_a     = a_zero ? '0 : {1'b1, fa, 2'b00};
  assign sig_b     = b_zero ? '0 : {1'b1, fb, 2'b00};
  assign sig_small = a_big ? sig_b : sig_a;
  assign e_big     = a_big ? ea : eb;
  assign e_small   = a_big ? eb : ea;
  assign e_diff    = e_big - e_small;

  always_comb begin
    spec_res = {sb, INF_MAG};
    if (a_nan || b_nan || (a_max && b_max && (sa != sb))) begin
      spec_res = QNAN;
    end else if (a_max) begin
      spec_res = {sa, INF_MAG};
    end
  end

  fp_align_shift #(
    .WIDTH   (ALN_W),
    .SHIFT_W (EXP_W)
  ) u_align (
    .din    (sig_small),
    .shamt  (e_diff),
    .dout   (aligned_sig),
    .sticky (aligned_sticky)
  );

  // Significand add/subtract (ADD); sticky sits in the LSB so borrows propagate correctly.
  logic [SIG_W-1:0] add_big, add_small, add_sum;

  assign add_big   = {1'b0, big_sig_reg, 1'b0};
  assign add_small = {1'b0, small_sig_reg, small_sticky_reg};
  assign add_sum   = eff_sub_reg ? (add_big - add_small) : (add_big + add_small);

  // Normalisation tests (NORM)
  logic sig_carry, sig_hidden, sig_is_zero;

  assign sig_carry   = sig_reg[SIG_W-1];
  assign sig_hidden  = sig_reg[MAN_W+3];
  assign sig_is_zero = (sig_reg == '0);

  // Round to nearest even with same-cycle renormalisation (ROUND)
  logic                  guard_b, round_b, sticky_b, lsb_b, round_up, inexact;
  logic [MAN_W+1:0]      mant_rnd;
  logic [MAN_W-1:0]      frac_rnd;
  logic signed [E_W-1:0] exp_rnd;
  logic [W-1:0]          round_res;
  logic [2:0]            round_flags;

  assign lsb_b    = sig_reg[3];
  assign guard_b  = sig_reg[2];
  assign round_b  = sig_reg[1];
  assign sticky_b = sig_reg[0];
  assign round_up = guard_b & (round_b | sticky_b | lsb_b);
  assign inexact  = guard_b | round_b | sticky_b;
  assign mant_rnd = {1'b0, sig_reg[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, round_up};

  always_comb begin
    frac_rnd    = mant_rnd[MAN_W-1:0];
    exp_rnd     = exp_reg;
    round_flags = '0;
    if (mant_rnd[MAN_W+1]) begin
      frac_rnd = mant_rnd[MAN_W:1];
      exp_rnd  = exp_reg + EXP_ONE;
    end
    if (exp_rnd >= EXP_ONES) begin
      round_res             = {sign_reg, INF_MAG};
      round_flags[FLAG_OVF] = 1'b1;
      round_flags[FLAG_INX] = 1'b1;
    end else if (exp_rnd <= EXP_ZERO) begin
      round_res             = {sign_reg, {(W-1){1'b0}}};
      round_flags[FLAG_UNF] = 1'b1;
      round_flags[FLAG_INX] = 1'b1;
    end else begin
      round_res             = {sign_reg, exp_rnd[EXP_W-1:0], frac_rnd};
      round_flags[FLAG_INX] = inexact;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_IDLE;
      in_ready_reg     <= 1'b1;
      out_valid_reg    <= 1'b0;
      result_reg       <= '0;
      flags_reg        <= '0;
      a_reg            <= '0;
      b_reg            <= '0;
      sub_reg          <= 1'b0;
      big_sig_reg      <= '0;
      small_sig_reg    <= '0;
      small_sticky_reg <= 1'b0;
      sig_reg          <= '0;
      exp_reg          <= '0;
      sign_reg         <= 1'b0;
      eff_sub_reg      <= 1'b0;
      special_reg      <= 1'b0;
      special_res_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg        <= a;
            b_reg        <= b;
            sub_reg      <= sub;
            in_ready_reg <= 1'b0;
            state_reg    <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          big_sig_reg      <= a_big ? sig_a : sig_b;
          small_sig_reg    <= aligned_sig;
          small_sticky_reg <= aligned_sticky;
          exp_reg          <= {2'b00, e_big};
          sign_reg         <= a_big ? sa : sb;
          eff_sub_reg      <= sa ^ sb;
          special_reg      <= a_max | b_max;
          special_res_reg  <= spec_res;
          state_reg        <= ST_ADD;
        end
        ST_ADD: begin
          if (special_reg) begin
            result_reg    <= special_res_reg;
            flags_reg     <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end else begin
            sig_reg   <= add_sum;
            state_reg <= ST_NORM;
          end
        end
        ST_NORM: begin
          // Exact cancellation always yields +0 regardless of operand signs.
          if (sig_is_zero) begin
            result_reg    <= '0;
            flags_reg     <= '0;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_DONE;
          end else if (sig_carry) begin
            sig_reg   <= {1'b0, sig_reg[SIG_W-1:2], sig_reg[1] | sig_reg[0]};
            exp_reg   <= exp_reg + EXP_ONE;
            state_reg <= ST_ROUND;
          end else if (sig_hidden) begin
            state_reg <= ST_ROUND;
          end else begin
            sig_reg <= sig_reg << 1;
            exp_reg <= exp_reg - EXP_ONE;
          end
        end
        ST_ROUND: begin
          result_reg    <= round_res;
          flags_reg     <= round_flags;
          out_valid_reg <= 1'b1;
          state_reg     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign result    = result_reg;
  assign flags     = flags_reg;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: directed vectors push expectations, a monitor checks each output.
// Also covers output hold under back-pressure and reset abort in the middle of normalisation.
module tb_fp_addsub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic [2:0]  flags;

  fp_addsub_seq #(
    .EXP_W (8),
    .MAN_W (23)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [2:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] va;
    logic [31:0] vb;
    logic        vs;
    logic [31:0] eres;
    logic [2:0]  eflg;
    int          elat;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic add_vec(input string name, input logic [31:0] va, input logic [31:0] vb,
                         input logic vs, input logic [31:0] eres, input logic [2:0] eflg,
                         input int elat);
    vec_t v;
    v.name = name; v.va = va; v.vb = vb; v.vs = vs;
    v.eres = eres; v.eflg = eflg; v.elat = elat;
    vecs.push_back(v);
  endtask

  // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
  task automatic send(input string name, input logic [31:0] va, input logic [31:0] vb,
                      input logic vs, input logic [31:0] eres, input logic [2:0] eflg,
                      input int elat, input bit track);
    int   waited;
    exp_t e;
    waited = 0;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_accept: in_ready still 0 after %0d cycles, required 1", name, waited);
      return;
    end
    a = va; b = vb; sub = vs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (track) begin
      e.name = name; e.res = eres; e.flg = eflg; e.lat = elat; e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0 || !in_ready) begin
      n_fail++;
      $display("FAIL drain: %0d results pending, in_ready=%0b after %0d cycles, required 0 pending",
               exp_q.size(), in_ready, budget);
    end
  endtask

  initial begin : monitor
    logic prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid && !prev_ov) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output: got result 0x%08h flags %03b, required no output",
                     result, flags);
          end else begin
            e = exp_q.pop_front();
            $display("txn %s: result=0x%08h flags=%03b latency=%0d", e.name, result, flags,
                     cyc - e.acc);
            check({e.name, "_result"}, result, e.res);
            check({e.name, "_flags"}, 32'(flags), 32'(e.flg));
            check({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int  n;
    bit  saw_valid;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'h0);
    check("reset_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;

    add_vec("add_one_one",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);
    add_vec("sub_three_one", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 4);
    add_vec("sub_cancel",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 3);
    add_vec("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 4);
    add_vec("round_up",      32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 3'b001, 4);
    add_vec("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b101, 4);
    add_vec("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b000, 2);
    add_vec("inf_plus_one",  32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 2);
    add_vec("nan_operand",   32'h3F800000, 32'hFFFFFFFF, 1'b0, 32'h7FC00000, 3'b000, 2);
    add_vec("neg_result",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 5);
    add_vec("underflow",     32'h00C00000, 32'h00800000, 1'b1, 32'h00000000, 3'b011, 5);
    add_vec("denorm_flush",  32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 4);

    foreach (vecs[i]) begin
      send(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].eres, vecs[i].eflg,
           vecs[i].elat, 1'b1);
    end
    drain(200);

    // Back-pressure: result must hold in DONE and new requests must be ignored.
    out_ready = 1'b0;
    send("hold", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_reached_done", 32'(out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      a = 32'h40400000;
      b = 32'h3F800000;
      sub = 1'b1;
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, 32'h40000000);
      check("hold_flags", 32'(flags), 32'd0);
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("release_stays_idle", 32'(in_ready), 32'd1);
    drain(50);

    // Reset during NORM: the aborted transaction must produce nothing.
    send("aborted", 32'h3F800001, 32'h3F800000, 1'b1, 32'h0, 3'b000, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    saw_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result", result, 32'h0);
    @(posedge clk); #1;
    if (out_valid) saw_valid = 1'b1;
    rst_n = 1'b1;
    send("after_abort", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 3'b000, 27, 1'b1);
    drain(100);
    check("abort_no_output", 32'(saw_valid), 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
